inst_loader: RTL and testbench

Boot-time writer for the processor's instruction memory. Accepts machine-code words from a host-side valid/ready stream, writes them to consecutive instruction-memory addresses starting at 0, then checks a trailing XOR checksum word. Sits between the host/testbench program source and the write port of the instruction memory that the program counter later reads; the core is held off via `Busy` until `Done` rises.

---
 rtl/loader_pkg.sv | 14 +
 rtl/inst_loader.sv | 118 +++++++++++
 tb/tb_inst_loader.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/loader_pkg.sv
// Shared types and default geometry for the instruction-memory boot loader.
package loader_pkg;

    localparam int A_DEF = 10;
    localparam int W_DEF = 9;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } ld_state_t;

endpackage

// File: rtl/inst_loader.sv
// Boot-time writer: streams host words into instruction memory from address 0,
// then compares a trailing XOR checksum word.
//
// state | meaning
// IDLE  | out of reset, waiting for Start
// LOAD  | accepting program words, one write per accepted word
// CHECK | waiting for the checksum word (never written to memory)
// DONE  | load finished, Err valid, stream ignored until next Start
module inst_loader
    import loader_pkg::*;
#(
    parameter int A = A_DEF,
    parameter int W = W_DEF
) (
    input  logic         Clk,
    input  logic         Reset_n,
    input  logic         Start,
    input  logic [A:0]   Len,
    input  logic         InValid,
    input  logic [W-1:0] InData,
    output logic         InReady,
    output logic         WrEn,
    output logic [A-1:0] WrAddr,
    output logic [W-1:0] WrData,
    output logic         Busy,
    output logic         Done,
    output logic         Err
);

    localparam logic [A:0] LEN_MAX = {1'b1, {A{1'b0}}};

    ld_state_t    state, next_state;
    logic [A:0]   cnt_q;
    logic [A:0]   len_q;
    logic [W-1:0] acc_q;
    logic         in_ready_q;
    logic         wr_en_q;
    logic [A-1:0] wr_addr_q;
    logic [W-1:0] wr_data_q;
    logic         busy_q;
    logic         done_q;
    logic         err_q;

    logic accept;
    logic start_ok;
    logic load_accept;
    logic last_word;

    assign accept      = InValid && in_ready_q;
    assign start_ok    = Start && (state == IDLE || state == DONE);
    assign load_accept = accept && (state == LOAD);
    assign last_word   = (cnt_q + (A+1)'(1)) == len_q;

    always_comb begin
        next_state = state;
        case (state)
            IDLE, DONE: begin
                if (Start) begin
                    if (Len == '0 || Len > LEN_MAX) next_state = DONE;
                    else                            next_state = LOAD;
                end
            end
            LOAD:    if (accept && last_word) next_state = CHECK;
            CHECK:   if (accept) next_state = DONE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state      <= IDLE;
            cnt_q      <= '0;
            len_q      <= '0;
            acc_q      <= '0;
            in_ready_q <= 1'b0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state      <= next_state;
            in_ready_q <= (next_state == LOAD) || (next_state == CHECK);
            // a word accepted on the last edge of LOAD still has its write in flight
            busy_q     <= (next_state == LOAD) || (next_state == CHECK) || load_accept;
            done_q     <= (next_state == DONE);
            wr_en_q    <= load_accept;

            if (start_ok) begin
                len_q <= Len;
                cnt_q <= '0;
                acc_q <= '0;
                err_q <= (Len > LEN_MAX);
            end

            if (load_accept) begin
                wr_addr_q <= cnt_q[A-1:0];
                wr_data_q <= InData;
                cnt_q     <= cnt_q + (A+1)'(1);
                acc_q     <= acc_q ^ InData;
            end

            if (accept && state == CHECK) begin
                err_q <= (InData != acc_q);
            end
        end
    end

    assign InReady = in_ready_q;
    assign WrEn    = wr_en_q;
    assign WrAddr  = wr_addr_q;
    assign WrData  = wr_data_q;
    assign Busy    = busy_q;
    assign Done    = done_q;
    assign Err     = err_q;

endmodule

// File: tb/tb_inst_loader.sv
// Scoreboard bench for inst_loader: driver queues expected writes, a negedge
// monitor pops and compares each WrEn pulse.
module tb_inst_loader;

    logic        Clk;
    logic        Reset_n;
    logic        Start;
    logic [10:0] Len;
    logic        InValid;
    logic [8:0]  InData;
    logic        InReady;
    logic        WrEn;
    logic [9:0]  WrAddr;
    logic [8:0]  WrData;
    logic        Busy;
    logic        Done;
    logic        Err;

    inst_loader #(.A(10), .W(9)) dut (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .Start   (Start),
        .Len     (Len),
        .InValid (InValid),
        .InData  (InData),
        .InReady (InReady),
        .WrEn    (WrEn),
        .WrAddr  (WrAddr),
        .WrData  (WrData),
        .Busy    (Busy),
        .Done    (Done),
        .Err     (Err)
    );

    typedef struct {
        logic [9:0] addr;
        logic [8:0] data;
        int         cyc;
    } wr_t;

    wr_t        exp_q[$];
    logic [8:0] prog[$];
    int         checks = 0;
    int         errors = 0;
    int         cycle  = 0;

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    always @(posedge Clk) cycle <= cycle + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every write strobe must match the oldest expected write, at the expected cycle.
    always @(negedge Clk) begin
        if (Reset_n && WrEn) begin
            if (exp_q.size() == 0) begin
                check("spurious_wren", 32'(WrAddr), 32'hFFFF_FFFF);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("wr_addr", 32'(WrAddr), 32'(e.addr));
                check("wr_data", 32'(WrData), 32'(e.data));
                check("wr_cycle", 32'(cycle), 32'(e.cyc));
            end
        end
    end

    function automatic logic [8:0] xor_of_prog();
        logic [8:0] x = '0;
        foreach (prog[i]) x = x ^ prog[i];
        return x;
    endfunction

    task automatic check_reset_outputs();
        check("rst_inready", 32'(InReady), 32'd0);
        check("rst_wren",    32'(WrEn),    32'd0);
        check("rst_wraddr",  32'(WrAddr),  32'd0);
        check("rst_wrdata",  32'(WrData),  32'd0);
        check("rst_busy",    32'(Busy),    32'd0);
        check("rst_done",    32'(Done),    32'd0);
        check("rst_err",     32'(Err),     32'd0);
    endtask

    // gap_mode: 0 none, 1 random, 2 fixed (1 idle before word 1, 3 idle before word 3)
    task automatic run_load(input logic [10:0] len, input logic [8:0] csum, input int gap_mode,
                            input bit exp_err, input int abort_after, input bit mid_start);
        int c0;
        int gaps;
        int nwords;
        int g;
        int t;
        @(negedge Clk);
        Start = 1'b1;
        Len   = len;
        c0    = cycle;
        @(negedge Clk);
        Start = 1'b0;
        if (len == 0 || len > 11'd1024) begin
            check("short_done",    32'(Done),    32'd1);
            check("short_err",     32'(Err),     32'(exp_err));
            check("short_inready", 32'(InReady), 32'd0);
            check("short_busy",    32'(Busy),    32'd0);
        end else begin
            check("load_inready", 32'(InReady), 32'd1);
            check("load_busy",    32'(Busy),    32'd1);
            check("load_done",    32'(Done),    32'd0);
            nwords = prog.size();
            gaps   = 0;
            for (int idx = 0; idx <= nwords; idx++) begin
                g = (gap_mode == 1) ? int'($urandom_range(0, 2)) :
                    (gap_mode == 2) ? ((idx == 1) ? 1 : (idx == 3) ? 3 : 0) : 0;
                repeat (g) begin
                    InValid = 1'b0;
                    InData  = 9'($urandom);
                    @(negedge Clk);
                    gaps++;
                end
                InValid = 1'b1;
                InData  = (idx < nwords) ? prog[idx] : csum;
                if (mid_start && idx == 1) begin
                    Start = 1'b1;
                    Len   = 11'd5;
                end
                t = 0;
                while (!InReady && t < 20) begin
                    @(negedge Clk);
                    t++;
                end
                if (!InReady) begin
                    check("accept_timeout", 32'(InReady), 32'd1);
                    InValid = 1'b0;
                    Start   = 1'b0;
                    return;
                end
                if (idx < nwords) exp_q.push_back('{addr: 10'(idx), data: prog[idx], cyc: cycle + 1});
                @(negedge Clk);
                Start = 1'b0;
                if (abort_after == idx + 1) begin
                    InValid = 1'b0;
                    return;
                end
                if (idx < nwords) check("busy_during_load", 32'(Busy), 32'd1);
            end
            InValid = 1'b0;
            check("end_done",    32'(Done),    32'd1);
            check("end_err",     32'(Err),     32'(exp_err));
            check("end_busy",    32'(Busy),    32'd0);
            check("end_inready", 32'(InReady), 32'd0);
            check("end_latency", 32'(cycle - c0), 32'(nwords + 2 + gaps));
            check("end_pending_writes", 32'(exp_q.size()), 32'd0);
        end
        // words offered while DONE must be ignored
        repeat (3) begin
            InValid = 1'b1;
            InData  = 9'($urandom);
            @(negedge Clk);
            check("idle_inready", 32'(InReady), 32'd0);
            check("idle_done",    32'(Done),    32'd1);
        end
        InValid = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [10:0] rlen;
        logic [8:0]  cs;
        bit          bad;

        Reset_n = 1'b0;
        Start   = 1'b0;
        Len     = '0;
        InValid = 1'b0;
        InData  = '0;
        repeat (2) @(negedge Clk);
        check_reset_outputs();
        Reset_n = 1'b1;

        prog = '{9'h001, 9'h0A5, 9'h1FF, 9'h100};
        run_load(11'd4, 9'h05B, 0, 1'b0, -1, 1'b0);
        run_load(11'd4, 9'h05A, 0, 1'b1, -1, 1'b0);
        run_load(11'd4, 9'h05B, 2, 1'b0, -1, 1'b0);

        prog = {};
        run_load(11'd0,     9'h000, 0, 1'b0, -1, 1'b0);
        run_load(11'h401,   9'h000, 0, 1'b1, -1, 1'b0);
        run_load(11'h7FF,   9'h000, 0, 1'b1, -1, 1'b0);

        for (int r = 0; r < 6; r++) begin
            rlen = 11'($urandom_range(1, 16));
            prog = {};
            for (int i = 0; i < int'(rlen); i++) prog.push_back(9'($urandom));
            bad = 1'($urandom_range(0, 1));
            cs  = xor_of_prog();
            if (bad) cs = cs ^ 9'($urandom_range(1, 511));
            run_load(rlen, cs, 1, bad, -1, 1'b0);
        end

        prog = {};
        for (int i = 0; i < 1024; i++) prog.push_back(9'(i));
        run_load(11'd1024, 9'h000, 0, 1'b0, -1, 1'b0);

        prog = '{9'h001, 9'h0A5, 9'h1FF, 9'h100};
        run_load(11'd4, 9'h05B, 0, 1'b0, 2, 1'b0);
        @(negedge Clk);
        #1 Reset_n = 1'b0;
        #1 check_reset_outputs();
        @(negedge Clk);
        Reset_n = 1'b1;
        check("abort_pending_writes", 32'(exp_q.size()), 32'd0);
        repeat (2) @(negedge Clk);

        prog = {};
        run_load(11'd0, 9'h000, 0, 1'b0, -1, 1'b0);

        prog = '{9'h123, 9'h0F0};
        run_load(11'd2, xor_of_prog(), 1, 1'b0, -1, 1'b1);

        repeat (3) @(negedge Clk);
        check("final_pending_writes", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
